// File: rtl/muldiv_sequencer_if.sv
// Bundle between the ID/EX stage and the iterative multiply/divide sequencer.
//   start_i  : ID/EX holds an M-extension op
//   op_i     : 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   rs1_i    : multiplicand / dividend
//   rs2_i    : multiplier / divisor
//   kill_i   : flush of the EX instruction
//   stall_o  : freeze PC, IF/ID and ID/EX
//   busy_o   : sequencer not idle
//   done_o   : result_o valid this cycle
//   result_o : result, held until the next completion
// master = pipeline side, slave = sequencer side.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            kill_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, kill_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, kill_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit for the EX stage (RV32M MUL, MULHU, DIVU, REMU).
// One bit per cycle: XLEN iterations, then a one-cycle done_o pulse carrying a registered
// result. The pipeline is stalled from the issue cycle until the DONE cycle.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : muldiv_sequencer_if.slave (start/op/operands/kill in, stall/busy/done/result out)
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  muldiv_sequencer_if.slave  bus
);

  localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      op_q;
  // Multiplicand for multiplies, divisor for divides.
  logic [XLEN-1:0] opnd_q;
  // hi: partial product high half / partial remainder.
  // lo: multiplier shifting out / dividend shifting out while quotient shifts in.
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] result_q;
  logic            busy_q;
  logic            done_q;

  // Shift-add multiply step.
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_nxt;
  logic [XLEN-1:0] mul_lo_nxt;

  // Restoring divide step.
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;
  logic [XLEN-1:0] div_hi_nxt;
  logic [XLEN-1:0] div_lo_nxt;

  logic [XLEN-1:0] hi_nxt;
  logic [XLEN-1:0] lo_nxt;
  logic [XLEN-1:0] res_nxt;

  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    // Shift {carry, hi, lo} right by one.
    mul_hi_nxt = mul_sum[XLEN:1];
    mul_lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
  end

  always_comb begin
    // Shift {rem, quo} left, pulling in the next dividend MSB from lo.
    div_shift  = {hi_q, lo_q[XLEN-1]};
    div_ge     = div_shift >= {1'b0, opnd_q};
    // When div_ge holds the difference always fits in XLEN bits.
    div_diff   = div_shift[XLEN-1:0] - opnd_q;
    div_hi_nxt = div_ge ? div_diff : div_shift[XLEN-1:0];
    div_lo_nxt = {lo_q[XLEN-2:0], div_ge};
  end

  // A zero divisor needs no special case: every compare succeeds, so the quotient fills
  // with ones and the remainder ends up equal to the dividend.
  always_comb begin
    hi_nxt  = op_q[1] ? div_hi_nxt : mul_hi_nxt;
    lo_nxt  = op_q[1] ? div_lo_nxt : mul_lo_nxt;
    // MUL/DIVU take the low register, MULHU/REMU the high one.
    res_nxt = op_q[0] ? hi_nxt : lo_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start_i && !bus.kill_i) begin
            op_q  <= bus.op_i;
            cnt_q <= CntW'(XLEN - 1);
            hi_q  <= '0;
            if (bus.op_i[1]) begin
              lo_q   <= bus.rs1_i;
              opnd_q <= bus.rs2_i;
            end else begin
              lo_q   <= bus.rs2_i;
              opnd_q <= bus.rs1_i;
            end
            busy_q  <= 1'b1;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (bus.kill_i) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            if (cnt_q == '0) begin
              result_q <= res_nxt;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        StDone: begin
          // start_i here still belongs to the instruction just completed.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Issue-cycle term lets ID/EX hold the instruction while operands are latched.
  assign bus.stall_o  = ~rst_i & (((state_q == StIdle) & bus.start_i & ~bus.kill_i) |
                                  (state_q == StBusy));
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int XLEN    = 32;
  localparam int LATENCY = 33;

  typedef struct {
    logic [XLEN-1:0] res;
    int              cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   mon_d;

  exp_t            exp_q[$];
  logic [XLEN-1:0] last_res;

  muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  // Reference: plain unsigned arithmetic with the RISC-V divide-by-zero rules.
  function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] p;
    p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    case (op)
      2'd0:    return p[XLEN-1:0];
      2'd1:    return p[2*XLEN-1:XLEN];
      2'd2:    return (b == 0) ? {XLEN{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: expected {busy, stall, done} is derived from cycles since issue.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() == 0) begin
        check("idle_status", 64'({bus.busy_o, bus.stall_o, bus.done_o}), 64'(3'b000));
        check("idle_result", 64'(bus.result_o), 64'(last_res));
      end else begin
        mon_d = cyc - exp_q[0].cyc;
        if (mon_d == 0) begin
          check("issue_status", 64'({bus.busy_o, bus.stall_o, bus.done_o}), 64'(3'b010));
          check("hold_result", 64'(bus.result_o), 64'(last_res));
        end else if (mon_d < LATENCY) begin
          check("busy_status", 64'({bus.busy_o, bus.stall_o, bus.done_o}), 64'(3'b110));
          check("hold_result", 64'(bus.result_o), 64'(last_res));
        end else begin
          check("done_status", 64'({bus.busy_o, bus.stall_o, bus.done_o}), 64'(3'b101));
          check("result", 64'(bus.result_o), 64'(exp_q[0].res));
          last_res = exp_q[0].res;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after DONE with start_i still high.
  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b);
    exp_t e;
    bus.start_i = 1'b1;
    bus.kill_i  = 1'b0;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    e.res = model(op, a, b);
    e.cyc = cyc;
    exp_q.push_back(e);
    for (int i = 0; i < LATENCY + 8 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: op %0d still pending, expected done within %0d cycles", op,
               LATENCY);
      exp_q.delete();
    end
  endtask

  task automatic gap(input int n);
    bus.start_i = 1'b0;
    bus.kill_i  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_t e;
    logic [1:0]      rop;
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
    cyc         = 0;
    n_tests     = 0;
    n_fail      = 0;
    last_res    = '0;
    rst         = 1'b1;
    bus.start_i = 1'b1;
    bus.kill_i  = 1'b0;
    bus.op_i    = 2'd0;
    bus.rs1_i   = 32'd3;
    bus.rs2_i   = 32'd4;
    #2;
    // Outputs quiet in reset even with start_i pending.
    check("reset_outputs", 64'({bus.result_o, bus.busy_o, bus.stall_o, bus.done_o}), 64'(0));
    bus.start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gap(2);

    // Directed cases.
    issue(2'd0, 32'd7, 32'd6);
    gap(3);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // back-to-back, start held through DONE
    gap(1);
    issue(2'd2, 32'd100, 32'd7);
    issue(2'd3, 32'd100, 32'd7);
    issue(2'd2, 32'h8000_0000, 32'd1);
    gap(2);
    issue(2'd2, 32'd1234, 32'd0);
    issue(2'd3, 32'd1234, 32'd0);
    gap(2);

    // Kill in IDLE: no launch, no stall.
    bus.start_i = 1'b1;
    bus.kill_i  = 1'b1;
    bus.op_i    = 2'd0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    gap(1);

    // Kill at cycle 10 of a MUL: back to idle, result keeps 1234.
    bus.start_i = 1'b1;
    bus.op_i    = 2'd0;
    bus.rs1_i   = 32'd11;
    bus.rs2_i   = 32'd13;
    e.res = model(2'd0, 32'd11, 32'd13);
    e.cyc = cyc;
    exp_q.push_back(e);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.kill_i = 1'b1;
    @(posedge clk);
    #1;
    void'(exp_q.pop_front());
    gap(3);

    // Asynchronous reset at cycle 20 of a MUL.
    bus.start_i = 1'b1;
    bus.op_i    = 2'd0;
    bus.rs1_i   = 32'd5;
    bus.rs2_i   = 32'd9;
    e.res = model(2'd0, 32'd5, 32'd9);
    e.cyc = cyc;
    exp_q.push_back(e);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", 64'({bus.result_o, bus.busy_o, bus.stall_o, bus.done_o}), 64'(0));
    bus.start_i = 1'b0;
    exp_q.delete();
    last_res = '0;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(2'd0, 32'd123, 32'd456);
    gap(1);

    // Randomized ops with random operand classes and gaps.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       ra = '1;
        2:       rb = 32'($urandom_range(1, 15));
        3:       ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      issue(rop, ra, rb);
      gap($urandom_range(0, 2));
    end
    gap(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
